// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI slave responder: word memory, delayed grant, in-order delayed responses
module obi_mem_responder #(
   parameter int MEM_WORDS       = 1024,
   parameter int GNT_DELAY       = 0,
   parameter int RSP_DELAY       = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o
);
   localparam int ADDR_W = $clog2(MEM_WORDS);
   localparam int QW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW     = $clog2(MAX_OUTSTANDING + 1);
   localparam int GW     = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
   localparam int TW     = (RSP_DELAY > 1) ? $clog2(RSP_DELAY) : 1;

   typedef enum logic {G_WAIT, G_READY} gstate_t;

   gstate_t         state, state_nxt;
   logic [GW-1:0]   gnt_cnt, gnt_cnt_nxt;
   logic [CW-1:0]   count;
   logic [QW-1:0]   wr_ptr, rd_ptr;
   logic            accept, pop;
   logic [31:0]     mem [MEM_WORDS];
   logic [31:0]     q_data [MAX_OUTSTANDING];
   logic [TW-1:0]   q_timer [MAX_OUTSTANDING];
   logic [ADDR_W-1:0] widx;
   logic            in_range;
   logic [31:0]     rsp_data;
   logic            unused_bits;

   assign unused_bits = &{1'b0, addr_i[1:0]};

   function automatic logic [QW-1:0] next_ptr(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= (GNT_DELAY == 0) ? G_READY : G_WAIT;
         gnt_cnt <= '0;
      end else begin
         state   <= state_nxt;
         gnt_cnt <= gnt_cnt_nxt;
      end
   end

   // Occupancy is the registered count, so a same-cycle pop never frees a slot for a grant.
   always_comb begin
      state_nxt   = state;
      gnt_cnt_nxt = gnt_cnt;
      gnt_o       = 1'b0;
      case (state)
         G_WAIT: begin
            if (!req_i) begin
               gnt_cnt_nxt = '0;
            end else begin
               gnt_cnt_nxt = gnt_cnt + GW'(1);
               if (gnt_cnt + GW'(1) == GW'(GNT_DELAY))
                  state_nxt = G_READY;
            end
         end
         G_READY: begin
            gnt_o = req_i & (count < CW'(MAX_OUTSTANDING)) & ~rst_i;
            if (gnt_o) begin
               gnt_cnt_nxt = '0;
               if (GNT_DELAY != 0)
                  state_nxt = G_WAIT;
            end
         end
         default: state_nxt = G_WAIT;
      endcase
   end

   assign accept   = gnt_o;
   assign widx     = addr_i[ADDR_W+1:2];
   assign in_range = (addr_i[31:ADDR_W+2] == '0);
   assign rsp_data = we_i ? 32'h0 : (in_range ? mem[widx] : 32'hBADC_AB1E);

   always_ff @(posedge clk_i) begin
      if (accept && we_i && in_range)
         for (int k = 0; k < 4; k++)
            if (be_i[k])
               mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
         if (q_timer[i] != '0)
            q_timer[i] <= q_timer[i] - TW'(1);
      if (accept) begin
         q_data[wr_ptr]  <= rsp_data;
         q_timer[wr_ptr] <= TW'(RSP_DELAY - 1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         if (accept && !pop)
            count <= count + CW'(1);
         else if (pop && !accept)
            count <= count - CW'(1);
      end
   end

   // No rready on OBI: the head leaves the queue on the cycle it is presented.
   assign pop      = (count != '0) && (q_timer[rd_ptr] == '0);
   assign rvalid_o = pop;
   assign rdata_o  = pop ? q_data[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - directed bench for obi_mem_responder in three parameterisations
module tb_obi_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, req0, we0, gnt0, rvalid0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0] be0;
   logic rst1, req1, we1, gnt1, rvalid1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [3:0] be1;
   logic rst2, req2, we2, gnt2, rvalid2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [3:0] be2;

   obi_mem_responder dut0 (
      .clk_i(clk), .rst_i(rst0), .req_i(req0), .addr_i(addr0), .be_i(be0), .we_i(we0),
      .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0));

   obi_mem_responder #(.GNT_DELAY(3), .RSP_DELAY(4)) dut1 (
      .clk_i(clk), .rst_i(rst1), .req_i(req1), .addr_i(addr1), .be_i(be1), .we_i(we1),
      .wdata_i(wdata1), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1));

   obi_mem_responder #(.RSP_DELAY(5), .MAX_OUTSTANDING(2)) dut2 (
      .clk_i(clk), .rst_i(rst2), .req_i(req2), .addr_i(addr2), .be_i(be2), .we_i(we2),
      .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic xfer0(input vec_t v, input int idx);
      @(negedge clk);
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; be0 = v.be; wdata0 = v.wdata;
      #1;
      check($sformatf("v%0d gnt", idx), gnt0, 1);
      check($sformatf("v%0d rvalid_early", idx), rvalid0, 0);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check($sformatf("v%0d gnt_idle", idx), gnt0, 0);
      check($sformatf("v%0d rvalid", idx), rvalid0, 1);
      check($sformatf("v%0d rdata", idx), rdata0, v.exp);
   endtask

   task automatic phase1(input int n, input int gnt_at, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; be1 = 4'hF;
         #1;
         check($sformatf("d1 gnt c%0d", c), gnt1, (c == gnt_at));
      end
   endtask

   task automatic resp1(input logic [31:0] exp);
      for (int d = 1; d <= 4; d++) begin
         @(negedge clk);
         req1 = 1'b0;
         #1;
         check($sformatf("d1 rvalid d%0d", d), rvalid1, (d == 4));
         if (d == 4) check("d1 rdata", rdata1, exp);
      end
   endtask

   task automatic xfer2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string nm);
      int n;
      @(negedge clk);
      req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata; be2 = 4'hF;
      #1;
      check({nm, " gnt"}, gnt2, 1);
      @(negedge clk);
      req2 = 1'b0;
      #1;
      n = 0;
      while (!rvalid2 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({nm, " rvalid"}, rvalid2, 1);
      check({nm, " latency"}, n, 4);
      check({nm, " rdata"}, rdata2, exp);
   endtask

   initial begin
      logic [12:0] eg, er;
      logic [31:0] addr_tab [3];
      logic [31:0] exp_tab [3];
      int issued, got, any_rv;

      vecs[0]  = '{1'b1, 32'h10,        4'hF,    32'h1234_5678, 32'h0};
      vecs[1]  = '{1'b0, 32'h10,        4'hF,    32'h0,         32'h1234_5678};
      vecs[2]  = '{1'b1, 32'h20,        4'hF,    32'hFFFF_FFFF, 32'h0};
      vecs[3]  = '{1'b1, 32'h20,        4'b0010, 32'h0000_AB00, 32'h0};
      vecs[4]  = '{1'b0, 32'h20,        4'hF,    32'h0,         32'hFFFF_ABFF};
      vecs[5]  = '{1'b0, 32'h23,        4'hF,    32'h0,         32'hFFFF_ABFF};
      vecs[6]  = '{1'b1, 32'h0,         4'hF,    32'hA5A5_A5A5, 32'h0};
      vecs[7]  = '{1'b1, 32'hFFFF_0000, 4'hF,    32'hDEAD_BEEF, 32'h0};
      vecs[8]  = '{1'b0, 32'hFFFF_0000, 4'hF,    32'h0,         32'hBADC_AB1E};
      vecs[9]  = '{1'b0, 32'h0,         4'hF,    32'h0,         32'hA5A5_A5A5};
      vecs[10] = '{1'b0, 32'h1000,      4'hF,    32'h0,         32'hBADC_AB1E};
      vecs[11] = '{1'b1, 32'hFFC,       4'hF,    32'h0F0F_0F0F, 32'h0};
      vecs[12] = '{1'b0, 32'hFFC,       4'hF,    32'h0,         32'h0F0F_0F0F};
      vecs[13] = '{1'b1, 32'hFFC,       4'b1001, 32'hAABB_CCDD, 32'h0};
      vecs[14] = '{1'b0, 32'hFFC,       4'hF,    32'h0,         32'hAA0F_0FDD};

      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
      we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
      addr0 = '0; addr1 = '0; addr2 = '0;
      be0 = 4'hF; be1 = 4'hF; be2 = 4'hF;
      wdata0 = '0; wdata1 = '0; wdata2 = '0;
      #2;
      check("rst gnt0", gnt0, 0);
      check("rst rvalid0", rvalid0, 0);
      check("rst rdata0", rdata0, 0);
      check("rst gnt1", gnt1, 0);
      check("rst gnt2", gnt2, 0);
      check("rst rvalid2", rvalid2, 0);
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;

      for (int i = 0; i < 15; i++) xfer0(vecs[i], i);

      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      #1;
      check("b2b gnt0", gnt0, 1);
      @(negedge clk);
      addr0 = 32'h20;
      #1;
      check("b2b gnt1", gnt0, 1);
      check("b2b rvalid0", rvalid0, 1);
      check("b2b rdata0", rdata0, 32'h1234_5678);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check("b2b rvalid1", rvalid0, 1);
      check("b2b rdata1", rdata0, 32'hFFFF_ABFF);
      @(negedge clk);
      #1;
      check("b2b idle", rvalid0, 0);

      phase1(4, 4, 1'b1, 32'h30, 32'hCAFE_F00D);
      resp1(32'h0);
      phase1(2, 0, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      req1 = 1'b0;
      #1;
      check("d1 gnt drop", gnt1, 0);
      phase1(4, 4, 1'b0, 32'h30, 32'h0);
      resp1(32'hCAFE_F00D);

      xfer2(1'b1, 32'h100, 32'h1111_1111, 32'h0, "d2 w0");
      xfer2(1'b1, 32'h104, 32'h2222_2222, 32'h0, "d2 w1");
      xfer2(1'b1, 32'h108, 32'h3333_3333, 32'h0, "d2 w2");
      addr_tab[0] = 32'h100; addr_tab[1] = 32'h104; addr_tab[2] = 32'h108;
      exp_tab[0] = 32'h1111_1111; exp_tab[1] = 32'h2222_2222; exp_tab[2] = 32'h3333_3333;
      eg = 13'h0043;
      er = 13'h0860;
      issued = 0;
      got = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         req2 = (issued < 3);
         we2 = 1'b0;
         addr2 = addr_tab[(issued < 3) ? issued : 0];
         #1;
         check($sformatf("d2 gnt c%0d", c), gnt2, eg[c]);
         check($sformatf("d2 rvalid c%0d", c), rvalid2, er[c]);
         if (rvalid2 && got < 3) begin
            check($sformatf("d2 rdata r%0d", got), rdata2, exp_tab[got]);
            got++;
         end
         if (gnt2) issued++;
      end
      check("d2 responses", got, 3);

      @(negedge clk);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h10C; wdata2 = 32'h4444_4444;
      #1;
      check("rst q gnt0", gnt2, 1);
      @(negedge clk);
      addr2 = 32'h110; wdata2 = 32'h5555_5555;
      #1;
      check("rst q gnt1", gnt2, 1);
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("rst q rvalid c%0d", c), rvalid2, (c == 5));
      end
      #2;
      rst2 = 1'b1;
      #1;
      check("async rst gnt", gnt2, 0);
      check("async rst rvalid", rvalid2, 0);
      check("async rst rdata", rdata2, 0);
      @(negedge clk);
      rst2 = 1'b0;
      req2 = 1'b0;
      any_rv = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (rvalid2) any_rv++;
      end
      check("post rst no rvalid", any_rv, 0);
      xfer2(1'b0, 32'h10C, 32'h0, 32'h4444_4444, "post rst read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
